// File: rtl/fc_fetch_ctrl_pkg.sv
// fc_pkg: shared types and default sizes for the FC operand fetch sequencer.
//   region_e : buffer region selector carried on wr_sel (X, W1, B1, W2, B2)
//   state_e  : fetch FSM state encodings
//   idx_width: index width helper, never narrower than one bit
package fc_pkg;

  localparam int DEF_WORD_SIZE      = 16;
  localparam int DEF_ADDRESS_SIZE   = 16;
  localparam int DEF_IP_LAYER_SIZE  = 128;
  localparam int DEF_OP_LAYER_SIZE  = 84;
  localparam int DEF_OP2_LAYER_SIZE = 10;

  typedef enum logic [2:0] {
    REG_X  = 3'd0,
    REG_W1 = 3'd1,
    REG_B1 = 3'd2,
    REG_W2 = 3'd3,
    REG_B2 = 3'd4
  } region_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic int idx_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fc_fetch_ctrl_if.sv
// fc_fetch_ctrl_if: RAM read port plus operand-buffer write bus.
//   ram_rd_en/ram_addr   : read request (master -> RAM)
//   ram_data/ram_valid   : read return  (RAM -> master)
//   wr_en/sel/row/col/data: buffer write strobe and index (master -> buffers)
interface fc_fetch_ctrl_if
  import fc_pkg::*;
#(
  parameter int WORD_SIZE    = DEF_WORD_SIZE,
  parameter int ADDRESS_SIZE = DEF_ADDRESS_SIZE,
  parameter int ROW_W        = idx_width(DEF_OP_LAYER_SIZE),
  parameter int COL_W        = idx_width(DEF_IP_LAYER_SIZE)
) ();

  logic                    ram_rd_en;
  logic [ADDRESS_SIZE-1:0] ram_addr;
  logic [WORD_SIZE-1:0]    ram_data;
  logic                    ram_valid;

  logic                    wr_en;
  logic [2:0]              wr_sel;
  logic [ROW_W-1:0]        wr_row;
  logic [COL_W-1:0]        wr_col;
  logic [WORD_SIZE-1:0]    wr_data;

  modport master (
    output ram_rd_en, ram_addr, wr_en, wr_sel, wr_row, wr_col, wr_data,
    input  ram_data, ram_valid
  );

  modport slave (
    input  ram_rd_en, ram_addr, wr_en, wr_sel, wr_row, wr_col, wr_data,
    output ram_data, ram_valid
  );

endinterface

// File: rtl/fc_fetch_ctrl_index_counter.sv
// fc_index_counter: row-major row/col counter with run-time bounds.
//   clk, reset (async, active-low)
//   clear_i   : force row/col to 0 (priority over inc_i)
//   inc_i     : step col, carrying into row at col_max_i
//   row_max_i/col_max_i : last valid row/col index of the current region
//   row_o/col_o : current index; last_o : index is (row_max, col_max)
module fc_index_counter #(
  parameter int ROW_W = 7,
  parameter int COL_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             inc_i,
  input  logic [ROW_W-1:0] row_max_i,
  input  logic [COL_W-1:0] col_max_i,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o,
  output logic             last_o
);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
    end else if (inc_i) begin
      if (col_q == col_max_i) begin
        col_d = '0;
        row_d = (row_q == row_max_i) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = (row_q == row_max_i) && (col_q == col_max_i);

endmodule

// File: rtl/fc_fetch_ctrl.sv
// fc_fetch_ctrl: walks X, W1, B1, W2, B2 contiguously from a latched base
// address, one outstanding RAM read at a time, and steers each returned word
// to its buffer with a registered write strobe.
//   clk, reset (async, active-low)
//   start_i / base_addr_i : begin a fetch (sampled in IDLE only)
//   abort_i               : cancel, back to IDLE without done
//   bus_if (master)       : RAM read port and buffer write bus
//   busy_o                : high outside IDLE
//   done_o                : one-cycle pulse, coincides with the last write
//
// state | meaning
// IDLE  | waiting for start
// REQ   | one-cycle read request at base + word count
// WAIT  | waiting for ram_valid, then capture the word
// DONE  | completion pulse
module fc_fetch_ctrl
  import fc_pkg::*;
#(
  parameter int WORD_SIZE      = DEF_WORD_SIZE,
  parameter int ADDRESS_SIZE   = DEF_ADDRESS_SIZE,
  parameter int IP_LAYER_SIZE  = DEF_IP_LAYER_SIZE,
  parameter int OP_LAYER_SIZE  = DEF_OP_LAYER_SIZE,
  parameter int OP2_LAYER_SIZE = DEF_OP2_LAYER_SIZE,
  parameter int ROW_W          = idx_width(OP_LAYER_SIZE),
  parameter int COL_W          = idx_width(IP_LAYER_SIZE)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [ADDRESS_SIZE-1:0] base_addr_i,
  fc_fetch_ctrl_if.master         bus_if,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam logic [1:0] ST_IDLE = 2'(S_IDLE);
  localparam logic [1:0] ST_REQ  = 2'(S_REQ);
  localparam logic [1:0] ST_WAIT = 2'(S_WAIT);
  localparam logic [1:0] ST_DONE = 2'(S_DONE);

  localparam logic [COL_W-1:0] IP_C  = COL_W'(IP_LAYER_SIZE - 1);
  localparam logic [COL_W-1:0] OP_C  = COL_W'(OP_LAYER_SIZE - 1);
  localparam logic [ROW_W-1:0] OP_R  = ROW_W'(OP_LAYER_SIZE - 1);
  localparam logic [ROW_W-1:0] OP2_R = ROW_W'(OP2_LAYER_SIZE - 1);

  logic [1:0]              state_q, state_d;
  logic [ADDRESS_SIZE-1:0] base_q, base_d;
  logic [ADDRESS_SIZE-1:0] word_q, word_d;
  region_e                 region_q, region_d;
  logic                    wr_en_q, wr_en_d;
  logic [2:0]              wr_sel_q, wr_sel_d;
  logic [ROW_W-1:0]        wr_row_q, wr_row_d;
  logic [COL_W-1:0]        wr_col_q, wr_col_d;
  logic [WORD_SIZE-1:0]    wr_data_q, wr_data_d;

  logic             cnt_clear, cnt_inc, cnt_last;
  logic [ROW_W-1:0] cnt_row, row_max;
  logic [COL_W-1:0] cnt_col, col_max;

  // Bounds of the region currently being filled (last row/col index).
  always_comb begin
    row_max = '0;
    col_max = '0;
    case (region_q)
      REG_X:   col_max = IP_C;
      REG_W1:  begin row_max = OP_R;  col_max = IP_C; end
      REG_B1:  row_max = OP_R;
      REG_W2:  begin row_max = OP2_R; col_max = OP_C; end
      default: row_max = OP2_R;
    endcase
  end

  fc_index_counter #(.ROW_W(ROW_W), .COL_W(COL_W)) u_idx (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (cnt_clear),
    .inc_i     (cnt_inc),
    .row_max_i (row_max),
    .col_max_i (col_max),
    .row_o     (cnt_row),
    .col_o     (cnt_col),
    .last_o    (cnt_last)
  );

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    word_d    = word_q;
    region_d  = region_q;
    wr_en_d   = 1'b0;
    wr_sel_d  = wr_sel_q;
    wr_row_d  = wr_row_q;
    wr_col_d  = wr_col_q;
    wr_data_d = wr_data_q;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          base_d    = base_addr_i;
          word_d    = '0;
          region_d  = REG_X;
          cnt_clear = 1'b1;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: state_d = abort_i ? ST_IDLE : ST_WAIT;
      ST_WAIT: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (bus_if.ram_valid) begin
          wr_en_d   = 1'b1;
          wr_sel_d  = region_q;
          wr_row_d  = cnt_row;
          wr_col_d  = cnt_col;
          wr_data_d = bus_if.ram_data;
          word_d    = word_q + ADDRESS_SIZE'(1);
          state_d   = ST_REQ;
          if (cnt_last) begin
            // Region boundary: restart the index counter for the next region.
            cnt_clear = 1'b1;
            if (region_q == REG_B2) state_d = ST_DONE;
            else                    region_d = region_e'(region_q + 3'd1);
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      word_q    <= '0;
      region_q  <= REG_X;
      wr_en_q   <= 1'b0;
      wr_sel_q  <= '0;
      wr_row_q  <= '0;
      wr_col_q  <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      word_q    <= word_d;
      region_q  <= region_d;
      wr_en_q   <= wr_en_d;
      wr_sel_q  <= wr_sel_d;
      wr_row_q  <= wr_row_d;
      wr_col_q  <= wr_col_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus_if.ram_rd_en = (state_q == ST_REQ);
  assign bus_if.ram_addr  = base_q + word_q;
  assign bus_if.wr_en     = wr_en_q;
  assign bus_if.wr_sel    = wr_sel_q;
  assign bus_if.wr_row    = wr_row_q;
  assign bus_if.wr_col    = wr_col_q;
  assign bus_if.wr_data   = wr_data_q;
  assign busy_o           = (state_q != ST_IDLE);
  assign done_o           = (state_q == ST_DONE);

endmodule

// File: tb/tb_fc_fetch_ctrl.sv
module tb_fc_fetch_ctrl;
  import fc_pkg::*;

  localparam int WS = 16, AS = 16, IP = 4, OP = 3, OP2 = 2;
  localparam int RW = idx_width(OP), CW = idx_width(IP);
  localparam int NWORDS = IP + OP*IP + OP + OP2*OP + OP2;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0;
  logic [AS-1:0] base = '0;
  logic busy, done;

  fc_fetch_ctrl_if #(.WORD_SIZE(WS), .ADDRESS_SIZE(AS), .ROW_W(RW), .COL_W(CW)) bus ();

  fc_fetch_ctrl #(.WORD_SIZE(WS), .ADDRESS_SIZE(AS), .IP_LAYER_SIZE(IP),
                  .OP_LAYER_SIZE(OP), .OP2_LAYER_SIZE(OP2)) dut (
    .clk(clk), .reset(reset), .start_i(start), .abort_i(abort),
    .base_addr_i(base), .bus_if(bus), .busy_o(busy), .done_o(done));

  always #5 clk = ~clk;

  typedef struct { logic [2:0] sel; logic [RW-1:0] row; logic [CW-1:0] col; logic [AS-1:0] addr; } wr_t;
  wr_t exp_q[$];
  logic [AS-1:0] addr_q[$];

  int n_chk = 0, n_fail = 0;
  int cyc = 0, start_cyc = 0;
  int wr_idx = 0, n_rd = 0, done_cnt = 0;
  int last_wr_rel = 0, done_rel = 0;
  int lat = 1;
  bit chk_timing = 0, spur = 0, noise = 0;
  logic [WS-1:0] salt = '0;
  logic [AS-1:0] got_addr[NWORDS];
  logic [WS-1:0] got_data[NWORDS];
  logic [2:0]    got_sel[NWORDS];
  logic [RW-1:0] got_row[NWORDS];
  logic [CW-1:0] got_col[NWORDS];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: five regions laid out back to back, each walked row-major.
  task automatic build_expected(input logic [AS-1:0] b);
    int rows[5] = '{1, OP, OP, OP2, OP2};
    int cols[5] = '{IP, IP, 1, OP, 1};
    logic [AS-1:0] a;
    wr_t e;
    a = b;
    exp_q.delete();
    addr_q.delete();
    for (int s = 0; s < 5; s++)
      for (int r = 0; r < rows[s]; r++)
        for (int c = 0; c < cols[s]; c++) begin
          e.sel = 3'(s); e.row = RW'(r); e.col = CW'(c); e.addr = a;
          exp_q.push_back(e);
          addr_q.push_back(a);
          a = a + 16'd1;
        end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // RAM: contents are addr ^ salt, returned lat cycles after the request.
  initial begin
    int cnt;
    logic [AS-1:0] pa;
    cnt = 0; pa = '0;
    bus.ram_valid = 1'b0;
    bus.ram_data  = '0;
    forever begin
      @(negedge clk);
      bus.ram_valid = 1'b0;
      if (!reset) cnt = 0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.ram_valid = 1'b1;
          bus.ram_data  = pa ^ salt;
        end
      end
      if (bus.ram_rd_en && reset) begin
        pa  = bus.ram_addr;
        cnt = lat;
        if (spur) begin
          bus.ram_valid = 1'b1;
          bus.ram_data  = 16'hDEAD;
        end
      end
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    wr_t e;
    logic [AS-1:0] a;
    if (bus.ram_rd_en) begin
      if (addr_q.size() == 0) chk("unexpected_rd", {16'h0, bus.ram_addr}, 32'hFFFF_FFFF);
      else begin
        a = addr_q.pop_front();
        chk("rd_addr", {16'h0, bus.ram_addr}, {16'h0, a});
      end
      if (n_rd < NWORDS) got_addr[n_rd] = bus.ram_addr;
      n_rd++;
    end
    if (bus.wr_en) begin
      if (exp_q.size() == 0) chk("unexpected_wr", {16'h0, bus.wr_data}, 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        chk("wr_sel",  {29'h0, bus.wr_sel}, {29'h0, e.sel});
        chk("wr_row",  32'(bus.wr_row), 32'(e.row));
        chk("wr_col",  32'(bus.wr_col), 32'(e.col));
        chk("wr_data", {16'h0, bus.wr_data}, {16'h0, e.addr ^ salt});
        if (chk_timing) chk("wr_cycle", cyc - start_cyc, 3 + 2*wr_idx);
      end
      if (wr_idx < NWORDS) begin
        got_data[wr_idx] = bus.wr_data; got_sel[wr_idx] = bus.wr_sel;
        got_row[wr_idx]  = bus.wr_row;  got_col[wr_idx] = bus.wr_col;
      end
      last_wr_rel = cyc - start_cyc;
      wr_idx++;
    end
    if (done) begin
      done_cnt++;
      done_rel = cyc - start_cyc;
      chk("done_with_last_wr", {30'h0, exp_q.size() == 0, bus.wr_en}, 32'h3);
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_rd_en"}, 32'(bus.ram_rd_en), 0);
    chk({tag, "_addr"},  32'(bus.ram_addr), 0);
    chk({tag, "_wr_en"}, 32'(bus.wr_en), 0);
    chk({tag, "_wr_sel"}, 32'(bus.wr_sel), 0);
    chk({tag, "_wr_row"}, 32'(bus.wr_row), 0);
    chk({tag, "_wr_col"}, 32'(bus.wr_col), 0);
    chk({tag, "_wr_data"}, 32'(bus.wr_data), 0);
  endtask

  task automatic start_fetch(input logic [AS-1:0] b);
    build_expected(b);
    wr_idx = 0; n_rd = 0;
    @(negedge clk); #1;
    base = b; start = 1'b1; start_cyc = cyc;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int d0, t;
    d0 = done_cnt; t = 0;
    while (done_cnt == d0 && t < 3000) begin
      @(negedge clk); #1;
      t++;
      if (noise && busy && wr_idx < NWORDS - 2) start = 1'($urandom_range(0, 1));
      else start = 1'b0;
    end
    start = 1'b0;
    chk("done_pulses", done_cnt - d0, 1);
    @(negedge clk); #1;
    chk("idle_after_done", 32'(busy), 0);
  endtask

  task automatic run_full(input logic [AS-1:0] b);
    start_fetch(b);
    wait_done();
    chk("wr_count", wr_idx, NWORDS);
    chk("rd_count", n_rd, NWORDS);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  task automatic flush();
    exp_q.delete();
    addr_q.delete();
  endtask

  initial begin
    int t, r0, d0, stop_at;
    #3 check_all_zero("reset");
    #20;
    @(negedge clk); #1 reset = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal fetch, data = address, latency 1.
    lat = 1; salt = '0; chk_timing = 1;
    run_full(16'h0100);
    chk("first_sel", 32'(got_sel[0]), 0);
    chk("first_row", 32'(got_row[0]), 0);
    chk("first_col", 32'(got_col[0]), 0);
    chk("first_data", 32'(got_data[0]), 32'h0100);
    chk("w1_r1c2_sel", 32'(got_sel[10]), 1);
    chk("w1_r1c2_row", 32'(got_row[10]), 1);
    chk("w1_r1c2_col", 32'(got_col[10]), 2);
    chk("w1_r1c2_data", 32'(got_data[10]), 32'h010A);
    chk("b1_start", {29'h0, got_sel[16], got_data[16]}, {29'h0, 3'd2, 16'h0110});
    chk("w2_start", {29'h0, got_sel[19], got_data[19]}, {29'h0, 3'd3, 16'h0113});
    chk("b2_start", {29'h0, got_sel[25], got_data[25]}, {29'h0, 3'd4, 16'h0119});
    chk("last_wr_cycle", last_wr_rel, 55);
    chk("done_cycle", done_rel, 55);

    // Latency 3.
    lat = 3; salt = 16'($urandom); chk_timing = 0;
    run_full(16'h0100);

    // Abort during W1, then restart at 0x0200.
    lat = 1; salt = 16'($urandom);
    start_fetch(16'h0040);
    t = 0;
    while (wr_idx < 6 && t < 500) begin @(negedge clk); #1; t++; end
    repeat ($urandom_range(0, 1)) begin @(negedge clk); #1; end
    d0 = done_cnt;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    flush();
    chk("abort_busy", 32'(busy), 0);
    chk("abort_rd_en", 32'(bus.ram_rd_en), 0);
    r0 = n_rd;
    repeat (10) @(negedge clk);
    #1;
    chk("abort_no_rd", n_rd - r0, 0);
    chk("abort_no_done", done_cnt - d0, 0);
    chk_timing = 1; salt = 16'($urandom);
    run_full(16'h0200);
    chk("restart_addr0", 32'(got_addr[0]), 32'h0200);
    chk("restart_sel_col", {29'h0, got_sel[0], 14'h0, got_col[0]}, 32'h0);

    // Spurious ram_valid (idle and in REQ) and start pulses while busy.
    @(negedge clk); #1 bus.ram_valid = 1'b1;
    repeat (2) @(negedge clk);
    spur = 1; noise = 1; salt = 16'($urandom);
    run_full(16'h0300);
    spur = 0; noise = 0;

    // Address wrap.
    chk_timing = 1; salt = 16'($urandom);
    run_full(16'hFFFE);
    chk("wrap_addr0", 32'(got_addr[0]), 32'hFFFE);
    chk("wrap_addr1", 32'(got_addr[1]), 32'hFFFF);
    chk("wrap_addr2", 32'(got_addr[2]), 32'h0000);
    chk("wrap_cols", {26'h0, got_col[0], got_col[1], got_col[2]}, {26'h0, 2'd0, 2'd1, 2'd2});

    // Random runs.
    for (int i = 0; i < 4; i++) begin
      lat = $urandom_range(1, 4);
      chk_timing = (lat == 1);
      salt = 16'($urandom);
      run_full(16'($urandom));
    end

    // Reset mid-stream.
    lat = $urandom_range(1, 3); chk_timing = 0; salt = 16'($urandom);
    start_fetch(16'($urandom));
    stop_at = $urandom_range(3, 20);
    t = 0;
    while (wr_idx < stop_at && t < 1000) begin @(negedge clk); #1; t++; end
    reset = 1'b0;
    #1 check_all_zero("midreset");
    flush();
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    r0 = n_rd; d0 = done_cnt;
    repeat (10) @(negedge clk);
    #1;
    chk("post_reset_no_rd", n_rd - r0, 0);
    chk("post_reset_no_done", done_cnt - d0, 0);
    chk("post_reset_busy", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fc_fetch_ctrl.md
Name: fc_fetch_ctrl

Overview:
Sequencer that loads the FC module's operand buffers (X, W_Layer1, B_Layer1, W_Layer2, B_Layer2) from RAM.
- On `start`, walks five contiguous RAM regions from a latched base address, issuing one read at a time.
- Each returned word is steered to the correct buffer via a registered write strobe with region/row/col index.
- Sits between the RAM port and the FC weight/input register files; signals `done` when all buffers are filled.

Parameters:
- WORD_SIZE, 16, data word width
- ADDRESS_SIZE, 16, RAM address width
- IP_LAYER_SIZE, 128, input vector length (X length, W1 columns)
- OP_LAYER_SIZE, 84, layer-1 outputs (W1 rows, B1 length, W2 columns)
- OP2_LAYER_SIZE, 10, layer-2 outputs (W2 rows, B2 length)
- Constraint: 1 ≤ OP2_LAYER_SIZE ≤ OP_LAYER_SIZE ≤ IP_LAYER_SIZE; total word count < 2^ADDRESS_SIZE
- Derived: ROW_W = max(1,$clog2(OP_LAYER_SIZE)), COL_W = max(1,$clog2(IP_LAYER_SIZE))

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin fetch; sampled only in IDLE
- abort  in  1  synchronous cancel; returns to IDLE, no `done`
- base_addr  in  ADDRESS_SIZE  RAM address of X[0]; latched on accepted start
- ram_rd_en  out  1  one-cycle read request
- ram_addr  out  ADDRESS_SIZE  read address, valid with ram_rd_en
- ram_data  in  WORD_SIZE  read data, valid with ram_valid
- ram_valid  in  1  read data return, ≥1 cycle after ram_rd_en
- wr_en  out  1  buffer write strobe (one cycle per word)
- wr_sel  out  3  region: 0=X 1=W1 2=B1 3=W2 4=B2
- wr_row  out  ROW_W  row index
- wr_col  out  COL_W  column index
- wr_data  out  WORD_SIZE  word to write
- busy  out  1  high outside IDLE
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0; counters and latched base cleared.
- FSM states:
  - IDLE: start=1 → latch base_addr, clear word/region/row/col counters → REQ.
  - REQ: ram_rd_en=1 for exactly one cycle; ram_addr = base + word_cnt (mod 2^ADDRESS_SIZE) → WAIT.
  - WAIT: hold until ram_valid=1. On valid, register wr_en=1 with wr_data=ram_data and the current sel/row/col, then advance counters. Next state is REQ, or DONE if this was the last word.
  - DONE: done=1 for one cycle → IDLE.
- The final word's wr_en pulse coincides with the DONE cycle; done is a Moore output.
- Region order and index layout:
  - X: IP words; row=0, col=0..IP-1.
  - W1: OP×IP words, row-major; row r, col c.
  - B1: OP words; row=0..OP-1, col=0.
  - W2: OP2×OP words, row-major.
  - B2: OP2 words; row=0..OP2-1, col=0.
- Region boundaries advance with no address gap; the address is always base + linear word count.
- Throughput: at most one outstanding read. With 1-cycle RAM latency the cost is 2 cycles/word, and wr_en for word k is high in cycle 3+2k after the start cycle.
- busy=1 in REQ/WAIT/DONE.
- wr_en=0 except the single cycle after valid data is captured; wr_sel/row/col/data hold their last value when wr_en=0.
- Ignored inputs:
  - start outside IDLE is ignored.
  - ram_valid outside WAIT is ignored (no write, no counter change).
- abort=1 in REQ/WAIT/DONE → IDLE next edge.
  - No further ram_rd_en; done is not pulsed; a pending wr_en is suppressed.
  - abort has priority over ram_valid in the same cycle.
- Address wrap: ram_addr wraps modulo 2^ADDRESS_SIZE with no error.
- Reset mid-operation: immediate return to IDLE with all outputs 0.

Decomposition:
- Package fc_pkg:
  - region enum (REG_X, REG_W1, REG_B1, REG_W2, REG_B2) with encodings 0..4
  - FSM state enum (IDLE, REQ, WAIT, DONE)
  - default size constants
- Sub-module fc_index_counter: a row/col counter with run-time row_max/col_max bounds, inc and clear inputs, and a last flag. It is instanced once and reloaded per region by the main FSM.

Test Plan:
1. Reset with reset=0 mid-stream → all outputs 0 immediately, busy=0, and no ram_rd_en after reset release until a new start.
2. Full fetch with IP=4, OP=3, OP2=2, base=0x0100, RAM returning data=addr with latency 1 → 27 wr_en pulses.
   - First pulse: sel=0 row0 col0 data 0x0100.
   - W1 (r1,c2) data 0x010A.
   - B1 starts at 0x0110; W2 at 0x0113; B2 at 0x0119.
   - Last write and done both in cycle 55.
3. RAM latency 3 → ram_rd_en stays a single pulse per word, no duplicate writes, and the data order matches scenario 2.
4. abort asserted while writing W1 → IDLE next cycle, busy=0, no done, no further reads; a new start with base 0x0200 restarts at X col0, addr 0x0200.
5. start pulsed during WAIT, and spurious ram_valid in REQ → no effect on address sequence or write count (still 27 writes).
6. base=0xFFFE → ram_addr sequence 0xFFFE, 0xFFFF, 0x0000, ...; writes indexed X col0, col1, col2 correctly.
